// File: rtl/prog_rom_pkg.sv
// Shared constants and types for the loadable program ROM bank.
package prog_rom_pkg;

    // Opcodes the default boot image and the out-of-range path rely on
    localparam logic [7:0] OP_NOP  = 8'b0000_0000;
    localparam logic [7:0] OP_LDI  = 8'b1100_0000;  // low nibble is the immediate
    localparam logic [7:0] OP_HALT = 8'b1000_1000;

    // Loader state machine
    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LOAD = 2'd1,
        LD_DONE = 2'd2,
        LD_ERR  = 2'd3
    } ld_state_e;

endpackage

// File: rtl/prog_rom_loader.sv
// Streaming loader: walks a write pointer through the memory, counts words,
// flags a write that would run past the last implemented word.
module prog_rom_loader
    import prog_rom_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    input  logic              valid,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic              busy,
    output logic              we,
    output logic [ADDR_W-1:0] waddr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    ld_state_e         state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   cnt;

    // State, pointer, count and sticky error; handshake outputs decode the state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LD_IDLE;
            ptr   <= '0;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                LD_IDLE: begin
                    if (start) begin
                        ptr   <= base;
                        cnt   <= len;
                        err   <= 1'b0;
                        state <= (len == '0) ? LD_DONE : LD_LOAD;
                    end
                end
                LD_LOAD: begin
                    if (valid) begin
                        ptr <= ptr + 1'b1;
                        cnt <= cnt - 1'b1;
                        // Final word wins over overflow: a load ending exactly on LAST is clean
                        if (cnt == (ADDR_W+1)'(1)) begin
                            state <= LD_DONE;
                        end else if (ptr == LAST) begin
                            state <= LD_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                LD_DONE: state <= LD_IDLE;
                LD_ERR:  state <= LD_IDLE;
                default: state <= LD_IDLE;
            endcase
        end
    end

    assign ready = (state == LD_LOAD);
    assign done  = (state == LD_DONE);
    assign busy  = (state != LD_IDLE);
    assign we    = ready && valid;
    assign waddr = ptr;

endmodule

// File: rtl/prog_rom_bank.sv
// Loadable instruction memory for the 8-bit core: 1-cycle fetch port,
// program entry table, and a streaming loader for run-time images.
module prog_rom_bank
    import prog_rom_pkg::*;
#(
    parameter int                         DATA_W     = 8,
    parameter int                         ADDR_W     = 8,
    parameter int                         DEPTH      = 256,
    parameter int                         NUM_PROG   = 3,
    parameter logic [NUM_PROG*ADDR_W-1:0] ENTRY_INIT = {8'd94, 8'd1, 8'd0},
    parameter logic [DATA_W-1:0]          HALT_OP    = DATA_W'(OP_HALT),
    localparam int                        SEL_W      = (NUM_PROG > 1) ? $clog2(NUM_PROG) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] address_i,
    output logic [DATA_W-1:0] data_o,
    output logic              rd_valid_o,
    output logic              oob_o,
    input  logic [SEL_W-1:0]  prog_sel_i,
    output logic [ADDR_W-1:0] entry_o,
    input  logic              ent_we_i,
    input  logic [ADDR_W-1:0] ent_addr_i,
    input  logic              ld_start_i,
    input  logic [ADDR_W-1:0] ld_base_i,
    input  logic [ADDR_W:0]   ld_len_i,
    input  logic              ld_valid_i,
    input  logic [DATA_W-1:0] ld_data_i,
    output logic              ld_ready_o,
    output logic              ld_done_o,
    output logic              ld_err_o,
    output logic              busy_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Power-up image: a tiny boot stub; the array is never cleared by reset
    logic [DATA_W-1:0] mem [DEPTH] = '{
        0:       DATA_W'(OP_NOP),
        1:       DATA_W'(OP_LDI | 8'd1),
        2:       HALT_OP,
        default: '0
    };

    logic [ADDR_W-1:0] ent_tab [NUM_PROG];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic              wr_ok;
    logic              rd_hit;
    logic              rd_oob;
    logic              sel_ok;

    prog_rom_loader #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_loader (
        .clk   (clk_i),
        .rst   (rst_i),
        .start (ld_start_i),
        .base  (ld_base_i),
        .len   (ld_len_i),
        .valid (ld_valid_i),
        .ready (ld_ready_o),
        .done  (ld_done_o),
        .err   (ld_err_o),
        .busy  (busy_o),
        .we    (mem_we),
        .waddr (mem_waddr)
    );

    assign wr_ok  = mem_we && !rst_i && (32'(mem_waddr) < 32'(DEPTH));
    assign rd_hit = rd_en_i && !busy_o;
    assign rd_oob = 32'(address_i) >= 32'(DEPTH);
    assign sel_ok = 32'(prog_sel_i) < 32'(NUM_PROG);

    // Loader writes; reset blocks the write so an aborted load stops cleanly
    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem[mem_waddr[IDX_W-1:0]] <= ld_data_i;
        end
    end

    // Fetch register: fetches are dropped while loading, data/oob hold when idle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_o     <= '0;
            rd_valid_o <= 1'b0;
            oob_o      <= 1'b0;
        end else begin
            rd_valid_o <= rd_hit;
            if (rd_hit) begin
                oob_o  <= rd_oob;
                data_o <= rd_oob ? HALT_OP : mem[address_i[IDX_W-1:0]];
            end
        end
    end

    // Entry table and its registered lookup; updates only while the loader is idle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_PROG; i++) begin
                ent_tab[i] <= ENTRY_INIT[i*ADDR_W +: ADDR_W];
            end
            entry_o <= '0;
        end else begin
            if (ent_we_i && !busy_o && sel_ok) begin
                ent_tab[prog_sel_i] <= ent_addr_i;
            end
            entry_o <= sel_ok ? ent_tab[prog_sel_i] : '0;
        end
    end

endmodule

// File: tb/tb_prog_rom_bank.sv
// Directed bench for prog_rom_bank: a DEPTH=256 instance for the main
// checks and a DEPTH=128 instance for the out-of-range fetch.
module tb_prog_rom_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic       rd_en;
    logic [7:0] address;
    logic [1:0] prog_sel;
    logic       ent_we;
    logic [7:0] ent_addr;
    logic       ld_start;
    logic [7:0] ld_base;
    logic [8:0] ld_len;
    logic       ld_valid;
    logic [7:0] ld_data;

    logic [7:0] data, entry;
    logic       rd_valid, oob, ld_ready, ld_done, ld_err, busy;
    logic [7:0] b_data, b_entry;
    logic       b_rd_valid, b_oob, b_ld_ready, b_ld_done, b_ld_err, b_busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    prog_rom_bank dut (
        .clk_i(clk), .rst_i(rst), .rd_en_i(rd_en), .address_i(address),
        .data_o(data), .rd_valid_o(rd_valid), .oob_o(oob),
        .prog_sel_i(prog_sel), .entry_o(entry), .ent_we_i(ent_we), .ent_addr_i(ent_addr),
        .ld_start_i(ld_start), .ld_base_i(ld_base), .ld_len_i(ld_len),
        .ld_valid_i(ld_valid), .ld_data_i(ld_data), .ld_ready_o(ld_ready),
        .ld_done_o(ld_done), .ld_err_o(ld_err), .busy_o(busy)
    );

    prog_rom_bank #(.DEPTH(128)) dut_b (
        .clk_i(clk), .rst_i(rst), .rd_en_i(rd_en), .address_i(address),
        .data_o(b_data), .rd_valid_o(b_rd_valid), .oob_o(b_oob),
        .prog_sel_i(prog_sel), .entry_o(b_entry), .ent_we_i(ent_we), .ent_addr_i(ent_addr),
        .ld_start_i(ld_start), .ld_base_i(ld_base), .ld_len_i(ld_len),
        .ld_valid_i(ld_valid), .ld_data_i(ld_data), .ld_ready_o(b_ld_ready),
        .ld_done_o(b_ld_done), .ld_err_o(b_ld_err), .busy_o(b_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one fetch and check the registered result on the next cycle
    task automatic fetch(input string tag, input logic [7:0] a, input logic [7:0] exp);
        rd_en   = 1'b1;
        address = a;
        tick();
        chk({tag, "_vld"}, 32'(rd_valid), 32'd1);
        chk(tag, 32'(data), 32'(exp));
    endtask

    initial begin
        rst = 1'b1; rd_en = 1'b0; address = '0; prog_sel = '0; ent_we = 1'b0; ent_addr = '0;
        ld_start = 1'b0; ld_base = '0; ld_len = '0; ld_valid = 1'b0; ld_data = '0;
        tick(); tick();

        // Reset state
        chk("rst_data",  32'(data),     32'd0);
        chk("rst_vld",   32'(rd_valid), 32'd0);
        chk("rst_oob",   32'(oob),      32'd0);
        chk("rst_ready", 32'(ld_ready), 32'd0);
        chk("rst_done",  32'(ld_done),  32'd0);
        chk("rst_err",   32'(ld_err),   32'd0);
        chk("rst_busy",  32'(busy),     32'd0);
        rst = 1'b0;

        // Entry table reset contents: slot0=0, slot1=1, slot2=94, slot3 invalid
        prog_sel = 2'd0; tick(); chk("ent_s0", 32'(entry), 32'd0);
        prog_sel = 2'd1; tick(); chk("ent_s1", 32'(entry), 32'd1);
        prog_sel = 2'd2; tick(); chk("ent_s2", 32'(entry), 32'd94);
        prog_sel = 2'd3; tick(); chk("ent_s3", 32'(entry), 32'd0);

        // Boot image fetches
        fetch("rd_a1", 8'd1, 8'b11000001);
        chk("rd_a1_oob", 32'(oob), 32'd0);
        fetch("rd_a2", 8'd2, 8'b10001000);

        // Out-of-range on the 128-deep instance
        rd_en = 1'b1; address = 8'd200; tick();
        chk("b_oob_vld",  32'(b_rd_valid), 32'd1);
        chk("b_oob_data", 32'(b_data),     32'h88);
        chk("b_oob_flag", 32'(b_oob),      32'd1);
        chk("a_200_oob",  32'(oob),        32'd0);
        rd_en = 1'b0; tick();
        chk("b_hold_vld",  32'(b_rd_valid), 32'd0);
        chk("b_hold_data", 32'(b_data),     32'h88);
        chk("b_hold_oob",  32'(b_oob),      32'd1);

        // Load 3 words at 200 with valid gaps; fetches during the load are dropped
        ld_start = 1'b1; ld_base = 8'd200; ld_len = 9'd3; tick();
        ld_start = 1'b0;
        chk("ld_busy",  32'(busy),     32'd1);
        chk("ld_ready", 32'(ld_ready), 32'd1);
        rd_en = 1'b1; address = 8'd1;
        ld_valid = 1'b1; ld_data = 8'hA1; tick();
        chk("ld_rdv0", 32'(rd_valid), 32'd0);
        ld_valid = 1'b0; tick();
        chk("ld_rdv1", 32'(rd_valid), 32'd0);
        chk("ld_nodone0", 32'(ld_done), 32'd0);
        ld_valid = 1'b1; ld_data = 8'hA2; tick();
        ld_valid = 1'b0; tick();
        chk("ld_nodone1", 32'(ld_done), 32'd0);
        ld_valid = 1'b1; ld_data = 8'hA3; tick();
        ld_valid = 1'b0;
        chk("ld_done", 32'(ld_done), 32'd1);
        chk("ld_rdv2", 32'(rd_valid), 32'd0);
        tick();
        chk("ld_done_once", 32'(ld_done), 32'd0);
        chk("ld_idle",      32'(busy),    32'd0);
        chk("ld_rdv3",      32'(rd_valid), 32'd0);
        fetch("rd_200", 8'd200, 8'hA1);
        fetch("rd_201", 8'd201, 8'hA2);
        fetch("rd_202", 8'd202, 8'hA3);
        rd_en = 1'b0;

        // Overflow: base 254, len 4 -> 254,255 written then ERR
        ld_start = 1'b1; ld_base = 8'd254; ld_len = 9'd4; tick();
        ld_start = 1'b0;
        ld_valid = 1'b1; ld_data = 8'h5E; tick();
        ld_data = 8'h5F; tick();
        ld_valid = 1'b0;
        chk("ovf_err",   32'(ld_err),   32'd1);
        chk("ovf_busy",  32'(busy),     32'd1);
        chk("ovf_ready", 32'(ld_ready), 32'd0);
        chk("ovf_done",  32'(ld_done),  32'd0);
        tick();
        chk("ovf_idle",   32'(busy),   32'd0);
        chk("ovf_sticky", 32'(ld_err), 32'd1);
        fetch("rd_254", 8'd254, 8'h5E);
        fetch("rd_255", 8'd255, 8'h5F);
        fetch("rd_0",   8'd0,   8'h00);
        rd_en = 1'b0;
        chk("ovf_sticky2", 32'(ld_err), 32'd1);

        // Zero-length load clears the error and goes straight to DONE
        ld_start = 1'b1; ld_base = 8'd10; ld_len = 9'd0; tick();
        ld_start = 1'b0;
        chk("z_err_clr", 32'(ld_err),  32'd0);
        chk("z_done",    32'(ld_done), 32'd1);
        tick();
        chk("z_idle", 32'(busy), 32'd0);

        // Entry write: visible two cycles after it is presented
        prog_sel = 2'd2; ent_addr = 8'd137; ent_we = 1'b1; tick();
        ent_we = 1'b0;
        chk("ew_old", 32'(entry), 32'd94);
        tick();
        chk("ew_new", 32'(entry), 32'd137);

        // Same write during LOAD is ignored
        ld_start = 1'b1; ld_base = 8'd50; ld_len = 9'd2; tick();
        ld_start = 1'b0;
        prog_sel = 2'd1; ent_addr = 8'd77; ent_we = 1'b1; tick();
        ent_we = 1'b0; tick();
        chk("ew_load", 32'(entry), 32'd1);
        // Write to invalid slot is ignored too; entry_o reads 0 for it
        ld_valid = 1'b1; ld_data = 8'h31; tick();
        ld_data = 8'h32; tick();
        ld_valid = 1'b0; tick();
        prog_sel = 2'd3; ent_we = 1'b1; ent_addr = 8'd55; tick();
        ent_we = 1'b0;
        chk("ew_bad_sel", 32'(entry), 32'd0);
        prog_sel = 2'd1; tick(); tick();
        chk("ew_s1_keep", 32'(entry), 32'd1);
        fetch("rd_51", 8'd51, 8'h32);
        rd_en = 1'b0;

        // Reset mid-load after 2 of 5 words
        ld_start = 1'b1; ld_base = 8'd100; ld_len = 9'd5; tick();
        ld_start = 1'b0;
        ld_valid = 1'b1; ld_data = 8'h11; tick();
        ld_data = 8'h22; tick();
        chk("ml_nodone0", 32'(ld_done), 32'd0);
        rst = 1'b1; ld_data = 8'h33; tick();
        rst = 1'b0; ld_valid = 1'b0;
        chk("ml_busy",  32'(busy),     32'd0);
        chk("ml_ready", 32'(ld_ready), 32'd0);
        chk("ml_done",  32'(ld_done),  32'd0);
        tick();
        chk("ml_nodone1", 32'(ld_done), 32'd0);
        fetch("rd_100", 8'd100, 8'h11);
        fetch("rd_101", 8'd101, 8'h22);
        fetch("rd_102", 8'd102, 8'h00);
        rd_en = 1'b0;
        chk("ml_nodone2", 32'(ld_done), 32'd0);
        prog_sel = 2'd2; tick();
        chk("ml_ent_init", 32'(entry), 32'd94);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
